// File: rtl/bfp_comp_pack_pkg.sv
// bfp_pkg: shared constants, sample-width type and beat-size helpers for the BFP packer
package bfp_pkg;
  localparam int BFP_EXP_W = 8;
  localparam int BFP_BEAT_W = 64;
  localparam int BFP_RB_BEATS = 6;
  localparam int BFP_MAX_BITS = BFP_EXP_W + 4 * 15;
  localparam int BFP_CNT_W = 8;
  typedef logic [3:0] bfp_width_t;
  function automatic logic [6:0] bfp_beat_bits(input logic [2:0] state, input bfp_width_t width);
    return width == '0 ? 7'(BFP_BEAT_W) : (state == '0 ? 7'(BFP_EXP_W) : 7'd0) + {1'b0, width, 2'b00};
  endfunction
  function automatic logic [7:0] bfp_keep(input logic [7:0] r);
    return ~(8'hFF >> ((r + 8'd7) >> 3));
  endfunction
endpackage

// File: rtl/bfp_comp_pack_acc.sv
// bfp_pack_acc: MSB-first bit accumulator emitting one 64-bit word per cycle, with end-of-packet flush
module bfp_pack_acc import bfp_pkg::*; #(
  parameter int ACC_W = 136
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [BFP_MAX_BITS-1:0] in_data,
  input  logic [6:0]              in_n,
  input  logic                    flush,
  output logic [BFP_BEAT_W-1:0]   word,
  output logic                    valid,
  output logic [7:0]              keep,
  output logic                    last,
  output logic                    sync,
  output logic                    pend,
  output logic                    ovf,
  output logic [BFP_CNT_W-1:0]    cnt
);
  localparam logic [BFP_CNT_W-1:0] W64 = BFP_CNT_W'(BFP_BEAT_W);
  localparam logic [BFP_CNT_W-1:0] WACC = BFP_CNT_W'(ACC_W);
  logic [ACC_W-1:0] acc, cat;
  logic [BFP_CNT_W-1:0] sum;
  logic fit, mid;
  always_comb begin
    sum = cnt + BFP_CNT_W'(in_n);
    fit = sum <= WACC;
    cat = acc | ({in_data & ~({BFP_MAX_BITS{1'b1}} >> in_n), {(ACC_W - BFP_MAX_BITS){1'b0}}} >> cnt);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      pend <= 1'b0;
      mid <= 1'b0;
      word <= '0;
      valid <= 1'b0;
      keep <= '0;
      last <= 1'b0;
      sync <= 1'b0;
      ovf <= 1'b0;
    end else begin
      ovf <= in_valid & ~pend & ~fit;
      valid <= 1'b0;
      if (pend) begin
        word <= acc[ACC_W-1 -: BFP_BEAT_W];
        valid <= 1'b1;
        sync <= mid;
        last <= cnt <= W64;
        keep <= cnt <= W64 ? bfp_keep(8'(cnt)) : 8'hFF;
        acc <= acc << BFP_BEAT_W;
        cnt <= cnt <= W64 ? '0 : cnt - W64;
        pend <= cnt > W64;
        mid <= cnt > W64;
      end else if (in_valid && fit) begin
        if (sum >= W64) begin
          word <= cat[ACC_W-1 -: BFP_BEAT_W];
          valid <= 1'b1;
          sync <= mid;
          last <= flush && sum == W64;
          keep <= 8'hFF;
          acc <= cat << BFP_BEAT_W;
          cnt <= sum - W64;
          mid <= !(flush && sum == W64);
        end else begin
          acc <= cat;
          cnt <= sum;
        end
        pend <= flush && sum != W64 && sum != '0;
      end
    end
  end
endmodule

// File: rtl/bfp_comp_pack.sv
// bfp_comp_pack: strips unused beat tail bits into a dense 64-bit stream; BFP_COMP_PACK_CHK_EN adds protocol checks
module bfp_comp_pack import bfp_pkg::*; #(
  parameter int ACC_W = 136
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BFP_BEAT_W-1:0] din_data,
  input  logic [2:0]            din_state,
  input  logic                  din_valid,
  input  logic                  din_sync,
  input  logic                  din_last,
  output logic [BFP_BEAT_W-1:0] dout_data,
  output logic [7:0]            dout_keep,
  output logic                  dout_valid,
  output logic                  dout_sync,
  output logic                  dout_last,
  output logic                  err,
  input  bfp_width_t            ud_iq_width
);
  bfp_width_t w_lat, w_cur;
  logic in_pkt, last_d, busy, gap_err, accept, chk_err, ovf, pend;
  logic s1_valid, s1_last;
  logic [BFP_MAX_BITS-1:0] s1_data;
  logic [6:0] s1_n;
  logic [BFP_CNT_W-1:0] cnt;
  assign w_cur = in_pkt ? w_lat : ud_iq_width;
  // a flush needing two more words would collide with the next beat's append
  assign busy = pend && cnt > BFP_CNT_W'(BFP_BEAT_W);
  assign gap_err = din_valid & (last_d | busy);
  assign accept = din_valid & ~gap_err;
`ifdef BFP_COMP_PACK_CHK_EN
  logic [2:0] prev_state, nxt_state;
  assign nxt_state = prev_state == 3'(BFP_RB_BEATS - 1) ? 3'd0 : prev_state + 3'd1;
  assign chk_err = accept & (in_pkt ? din_state != nxt_state : (din_state != 3'd0 || din_sync));
  always_ff @(posedge clk) begin
    if (rst) prev_state <= '0;
    else if (accept) prev_state <= din_state;
  end
`else
  logic unused_sync;
  assign unused_sync = din_sync;
  assign chk_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      w_lat <= '0;
      in_pkt <= 1'b0;
      last_d <= 1'b0;
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_n <= '0;
      s1_last <= 1'b0;
      err <= 1'b0;
    end else begin
      last_d <= accept & din_last;
      if (accept) begin
        w_lat <= w_cur;
        in_pkt <= ~din_last;
      end
      s1_valid <= accept;
      s1_data <= {din_data, {(BFP_MAX_BITS - BFP_BEAT_W){1'b0}}};
      s1_n <= bfp_beat_bits(din_state, w_cur);
      s1_last <= din_last;
      err <= err | gap_err | ovf | chk_err;
    end
  end
  bfp_pack_acc #(.ACC_W(ACC_W)) u_acc (
    .clk(clk),
    .rst(rst),
    .in_valid(s1_valid),
    .in_data(s1_data),
    .in_n(s1_n),
    .flush(s1_last),
    .word(dout_data),
    .valid(dout_valid),
    .keep(dout_keep),
    .last(dout_last),
    .sync(dout_sync),
    .pend(pend),
    .ovf(ovf),
    .cnt(cnt)
  );
endmodule

// File: tb/tb_bfp_comp_pack.sv
// tb_bfp_comp_pack: directed packets checked against a bit-queue model and hand-computed word counts/keeps
module tb_bfp_comp_pack;
  logic clk = 1'b0, rst;
  logic [63:0] din_data;
  logic [2:0] din_state;
  logic din_valid, din_sync, din_last;
  logic [63:0] dout_data;
  logic [7:0] dout_keep;
  logic dout_valid, dout_sync, dout_last, err;
  logic [3:0] ud_iq_width;
  int n_chk = 0, n_pass = 0, cyc = 0, t0 = 0;
  bit bits[$];
  logic [63:0] exp_d[$], got_d[$];
  logic [7:0] exp_k[$], got_k[$];
  logic got_l[$], got_s[$];
  int got_c[$];
  bfp_comp_pack dut (
    .clk(clk), .rst(rst), .din_data(din_data), .din_state(din_state), .din_valid(din_valid),
    .din_sync(din_sync), .din_last(din_last), .dout_data(dout_data), .dout_keep(dout_keep),
    .dout_valid(dout_valid), .dout_sync(dout_sync), .dout_last(dout_last), .err(err),
    .ud_iq_width(ud_iq_width)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (dout_valid) begin
    got_d.push_back(dout_data);
    got_k.push_back(dout_keep);
    got_l.push_back(dout_last);
    got_s.push_back(dout_sync);
    got_c.push_back(cyc);
  end
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic int beat_bits(int st, int w);
    return w == 0 ? 64 : (st == 0 ? 8 : 0) + 4 * w;
  endfunction
  task automatic send_pkt(int w, int nb, int w_mid, logic [7:0] ex, bit do_last);
    logic [63:0] d;
    int st, n;
    for (int i = 0; i < nb; i++) begin
      d = {$urandom, $urandom};
      st = i % 6;
      if (st == 0) d[63:56] = ex;
      n = beat_bits(st, w);
      for (int b = 0; b < n; b++) bits.push_back(b < 64 ? d[63-b] : 1'b0);
      if (i == 0) t0 = cyc;
      din_data = d;
      din_state = 3'(st);
      din_valid = 1'b1;
      din_last = do_last && i == nb - 1;
      ud_iq_width = i == 0 ? 4'(w) : 4'(w_mid);
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    din_last = 1'b0;
  endtask
  task automatic model_flush();
    logic [63:0] w;
    int r;
    while (bits.size() > 0) begin
      w = '0;
      r = bits.size() < 64 ? bits.size() : 64;
      for (int i = 0; i < r; i++) w[63-i] = bits.pop_front();
      exp_d.push_back(w);
      exp_k.push_back(~(8'hFF >> ((r + 7) / 8)));
    end
  endtask
  task automatic clear_q();
    got_d.delete(); got_k.delete(); got_l.delete(); got_s.delete(); got_c.delete();
    exp_d.delete(); exp_k.delete(); bits.delete();
  endtask
  task automatic cmp_pkt(string tag, int nw, logic [7:0] lk, int lat);
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_nwords"}, got_d.size(), nw);
    if (got_k.size() > 0) check({tag, "_lastkeep"}, got_k[got_k.size()-1], lk);
    if (lat >= 0 && got_c.size() > 0) check({tag, "_latency"}, got_c[0] - t0, lat);
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
      check($sformatf("%s_keep%0d", tag, i), got_k[i], exp_k[i]);
      check($sformatf("%s_last%0d", tag, i), got_l[i], i == exp_d.size() - 1);
      check($sformatf("%s_sync%0d", tag, i), got_s[i], i != 0);
      if (lat >= 0) check($sformatf("%s_cyc%0d", tag, i), got_c[i] - got_c[0], i);
    end
    clear_q();
  endtask
  initial begin
    rst = 1'b1; din_data = '0; din_state = '0; din_valid = 1'b0; din_sync = 1'b0;
    din_last = 1'b0; ud_iq_width = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", dout_valid, 0);
    check("rst_data", dout_data, 0);
    check("rst_keep", dout_keep, 0);
    check("rst_sync", dout_sync, 0);
    check("rst_last", dout_last, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    send_pkt(9, 6, 9, 8'h5C, 1'b1);
    model_flush();
    cmp_pkt("w9", 4, 8'hF0, -1);
    send_pkt(8, 6, 8, 8'h0A, 1'b1);
    model_flush();
    check("w8_exp_byte", exp_d.size() > 0 ? 64'(exp_d[0][63:56]) : 64'hDEAD, 8'h0A);
    if (got_d.size() == 0) repeat (4) @(posedge clk);
    #1;
    check("w8_word0_exp", got_d.size() > 0 ? 64'(got_d[0][63:56]) : 64'hDEAD, 8'h0A);
    cmp_pkt("w8", 4, 8'h80, -1);
    send_pkt(15, 60, 15, 8'h3F, 1'b1);
    model_flush();
    cmp_pkt("w15", 58, 8'hF0, -1);
    check("w15_err", err, 0);
    send_pkt(0, 6, 0, 8'h01, 1'b1);
    model_flush();
    cmp_pkt("pt", 6, 8'hFF, 2);
    send_pkt(9, 6, 4, 8'h77, 1'b1);
    model_flush();
    cmp_pkt("wchg", 4, 8'hF0, -1);
    send_pkt(9, 3, 9, 8'h11, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", dout_valid, 0);
    check("mid_rst_data", dout_data, 0);
    check("mid_rst_keep", dout_keep, 0);
    rst = 1'b0;
    clear_q();
    send_pkt(9, 6, 9, 8'h22, 1'b1);
    model_flush();
    cmp_pkt("post_rst", 4, 8'hF0, -1);
    check("pre_gap_err", err, 0);
    send_pkt(9, 6, 9, 8'h33, 1'b1);
    din_valid = 1'b1; din_state = 3'd0; din_last = 1'b1; din_data = '1;
    @(posedge clk); #1;
    din_valid = 1'b0; din_last = 1'b0;
    model_flush();
    cmp_pkt("gap", 4, 8'hF0, -1);
    check("gap_err", err, 1);
`ifdef BFP_COMP_PACK_CHK_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("chk_err_clr", err, 0);
    ud_iq_width = 4'd9;
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1; din_state = i == 2 ? 3'd3 : 3'(i); din_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("chk_seq_err", err, 1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bfp_comp_pack.md
Name: bfp_comp_pack

Overview:
- Sits directly downstream of the BFP exponent/shift compressor.
- Each upstream beat carries left-aligned packed bits:
  - State-0 beats: 8-bit exponent byte followed by 4 samples of ud_iq_width bits.
  - All other beats: 4 samples only.
- The block removes the unused tail bits of every beat and concatenates the valid bits into a dense 64-bit word stream, MSB first.
- At packet end it zero-pads the last word and flags its valid bytes. Output goes to the framing/ethernet stage.

Parameters:
- ACC_W, 136, accumulator width in bits; must be ≥ 132.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- din_data  in  64  left-aligned packed bits from compressor
- din_state  in  3  RB beat index 0..5; 0 = beat carrying exponent byte
- din_valid  in  1  beat valid
- din_sync  in  1  upstream sync; ignored except under BFP_COMP_PACK_CHK_EN
- din_last  in  1  last beat of packet
- dout_data  out  64  packed word; first packet bit at [63]
- dout_keep  out  8  byte enables, [7] = bits 63:56
- dout_valid  out  1  word valid
- dout_sync  out  1  0 on first word of packet, 1 on following words
- dout_last  out  1  final word of packet
- err  out  1  sticky protocol error
- ud_iq_width  in  4  sample width; 0 = passthrough

Behaviour:
- Clock and reset:
  - Single clock clk. rst is synchronous, active-high.
  - On reset: all outputs 0; accumulator count 0; packet state IDLE.
- Width latching:
  - ud_iq_width is sampled on the first valid beat of a packet (state IDLE) and held until that packet's last beat is consumed.
  - Changes mid-packet have no effect.
- Bits per beat (W = latched width, 1..15):
  - din_state==0: 8+4W bits.
  - Otherwise: 4W bits.
  - Maximum 68 bits.
- Passthrough: W=0 means 64 bits per beat, data forwarded unmodified, all keep bits 1.
- Pipeline:
  - s1 registers data, bit count and last.
  - s2 appends the bits at accumulator position count (MSB-first) and count += n.
  - When count ≥ 64, the top 64 bits are emitted on the registered output and the accumulator shifts left by 64.
  - At most one output word per cycle.
  - Latency: input beat to the output word that completes with its bits is 2 cycles.
- Flush on last beat:
  - After appending, emit any full word first.
  - If residual r > 0 remains, the next cycle emits a zero-padded word with dout_last=1 and dout_keep = top ceil(r/8) bits set.
  - If residual is 0, the full word carries dout_last=1 with keep 8'hFF.
  - Then return to IDLE with count 0.
- Gap requirement: upstream guarantees at least 1 idle cycle after din_last. A valid beat during a pending flush sets err and is dropped.
- Accumulator sizing:
  - Count bound before emit is ≤ 131.
  - Any append that would exceed ACC_W sets err and drops the beat.
- Reset mid-packet discards the residual; no partial word is emitted.
- err is sticky and cleared only by rst.

Optional Feature:
- Macro: BFP_COMP_PACK_CHK_EN.
- When defined, adds protocol checks, each setting err:
  - din_state sequence not 0,1,..,5,0 within a packet.
  - First beat of a packet with din_state≠0.
  - din_sync=1 on the first beat.
- When undefined, only the overflow and flush-collision checks drive err.

Decomposition:
- Package bfp_pkg holds:
  - BFP_EXP_W=8, BFP_BEAT_W=64, BFP_RB_BEATS=6.
  - Function bfp_beat_bits(state, width).
  - Typedef for the 4-bit width.
- Sub-module bfp_pack_acc: bit accumulator/gearbox.
  - Inputs: data, n, flush.
  - Outputs: word, valid, residual count.
  - Instantiated once.

Test Plan:
- W=9, one RB (6 beats, last on beat 5): 224 bits in.
  - Expect 4 words out; words 0–2 keep FF.
  - Word 3: keep 8'hF0, low 32 bits zero, dout_last=1.
  - dout_sync pattern 0,1,1,1.
- W=8, one RB, exponent 4'hA: word0[63:56]=8'h0A; total 200 bits → final word keep 8'h80.
- W=15, 10 back-to-back RBs, last on final beat: 3680 bits → 58 words, last keep 8'hF0, err stays 0, count never exceeds 131.
- W=0 passthrough, 6 beats of incrementing pattern: identical 6 words out, 2-cycle latency, last on word 5.
- ud_iq_width changed 9→4 mid-packet: output is bit-identical to the constant W=9 run. Then rst asserted mid-packet: outputs 0 next cycle, and the next packet's first bit lands at [63].
- Valid beat on the cycle after din_last with residual pending: err=1 and the beat is dropped. With BFP_COMP_PACK_CHK_EN defined, a state sequence 0,1,3 sets err.
